// File: rtl/reg_xfer_pkg.sv
// Shared types and default widths for the register-transfer controller and its bank port.
package reg_xfer_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;

   typedef enum logic [1:0] {OP_RD, OP_MOV, OP_LDI, OP_SWAP} xfer_op_e;

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SWAP_A, S_SWAP_B, S_SWAP_C} xfer_state_e;
endpackage

// File: rtl/reg_transfer_ctrl_if.sv
// Command handshake from the decoder plus the read/write port of the 8x8 register bank.
interface reg_transfer_ctrl_if #(
   parameter int DATA_W = reg_xfer_pkg::DATA_W,
   parameter int ADDR_W = reg_xfer_pkg::ADDR_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_dst;
   logic [ADDR_W-1:0] cmd_src;
   logic [DATA_W-1:0] cmd_imm;
   logic [ADDR_W-1:0] bank_wsel;
   logic              bank_we;
   logic [DATA_W-1:0] bank_din;
   logic [ADDR_W-1:0] bank_rsel;
   logic [DATA_W-1:0] bank_dout;
   logic              done;
   logic [DATA_W-1:0] rd_data;

   modport master (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, bank_dout,
      output cmd_ready, bank_wsel, bank_we, bank_din, bank_rsel, done, rd_data
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, bank_dout,
      input  cmd_ready, bank_wsel, bank_we, bank_din, bank_rsel, done, rd_data
   );
endinterface

// File: rtl/reg_transfer_ctrl.sv
// Sequences RD/MOV/LDI/SWAP commands onto a write-gated register bank with a combinational read path.
// One command in flight; cmd_ready only in IDLE, so a new command may be accepted in the done cycle.
module reg_transfer_ctrl #(
   parameter int DATA_W = reg_xfer_pkg::DATA_W,
   parameter int ADDR_W = reg_xfer_pkg::ADDR_W
) (
   input  logic                 CLK,
   input  logic                 RESET,
   reg_transfer_ctrl_if.master  bus
);
   import reg_xfer_pkg::*;

   localparam logic [2:0] ST_IDLE   = S_IDLE;
   localparam logic [2:0] ST_EXEC   = S_EXEC;
   localparam logic [2:0] ST_SWAP_A = S_SWAP_A;
   localparam logic [2:0] ST_SWAP_B = S_SWAP_B;
   localparam logic [2:0] ST_SWAP_C = S_SWAP_C;

   logic [2:0]        state, state_nxt;
   xfer_op_e          op_q;
   logic [ADDR_W-1:0] dst_q, src_q;
   logic [DATA_W-1:0] imm_q, temp_q, rd_data_q;
   logic              done_q;
   logic              accept;

   assign bus.cmd_ready = (state == ST_IDLE);
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign bus.done      = done_q;
   assign bus.rd_data   = rd_data_q;

   always_comb begin
      state_nxt     = state;
      bus.bank_rsel = '0;
      bus.bank_wsel = '0;
      bus.bank_din  = '0;
      bus.bank_we   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept)
               state_nxt = (xfer_op_e'(bus.cmd_op) == OP_SWAP) ? ST_SWAP_A : ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt = ST_IDLE;
            case (op_q)
               OP_RD: bus.bank_rsel = src_q;
               OP_MOV: begin
                  bus.bank_rsel = src_q;
                  bus.bank_wsel = dst_q;
                  bus.bank_din  = bus.bank_dout;
                  bus.bank_we   = 1'b1;
               end
               OP_LDI: begin
                  bus.bank_wsel = dst_q;
                  bus.bank_din  = imm_q;
                  bus.bank_we   = 1'b1;
               end
               default: ;
            endcase
         end
         // SWAP: park src in temp, copy dst into src, then write temp into dst
         ST_SWAP_A: begin
            state_nxt     = ST_SWAP_B;
            bus.bank_rsel = src_q;
         end
         ST_SWAP_B: begin
            state_nxt     = ST_SWAP_C;
            bus.bank_rsel = dst_q;
            bus.bank_wsel = src_q;
            bus.bank_din  = bus.bank_dout;
            bus.bank_we   = 1'b1;
         end
         ST_SWAP_C: begin
            state_nxt     = ST_IDLE;
            bus.bank_wsel = dst_q;
            bus.bank_din  = temp_q;
            bus.bank_we   = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= ST_IDLE;
         op_q      <= OP_RD;
         dst_q     <= '0;
         src_q     <= '0;
         imm_q     <= '0;
         temp_q    <= '0;
         rd_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == ST_EXEC) || (state == ST_SWAP_C);
         if (accept) begin
            op_q  <= xfer_op_e'(bus.cmd_op);
            dst_q <= bus.cmd_dst;
            src_q <= bus.cmd_src;
            imm_q <= bus.cmd_imm;
         end
         if (state == ST_EXEC && op_q == OP_RD)
            rd_data_q <= bus.bank_dout;
         if (state == ST_SWAP_A)
            temp_q <= bus.bank_dout;
      end
   end
endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Controller driving a behavioural write-gated 8x8 bank, checked against an array-level reference model.
module tb_reg_transfer_ctrl;
   import reg_xfer_pkg::*;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   reg_transfer_ctrl_if bus ();
   reg_transfer_ctrl dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   // register bank: combinational read, write on the clock edge when bank_we
   logic [7:0] regs [8];
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      end else if (bus.bank_we) begin
         regs[bus.bank_wsel] <= bus.bank_din;
      end
   end
   assign bus.bank_dout = regs[bus.bank_rsel];

   int checks = 0;
   int passed = 0;

   logic [7:0] model [8];
   logic [7:0] model_rd;

   task automatic model_clear();
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      model_rd = 8'h00;
   endtask

   task automatic model_apply(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                              input logic [7:0] imm);
      logic [7:0] a, b;
      case (op)
         2'd0: model_rd = model[src];
         2'd1: model[dst] = model[src];
         2'd2: model[dst] = imm;
         default: begin
            a = model[src];
            b = model[dst];
            model[src] = b;
            model[dst] = a;
         end
      endcase
   endtask

   function automatic int first_mismatch();
      for (int i = 0; i < 8; i++)
         if (regs[3'(i)] !== model[3'(i)]) return i;
      return -1;
   endfunction

   function automatic int exp_lat(input logic [1:0] op);
      return (op == 2'd3) ? 4 : 2;
   endfunction

   function automatic int exp_we(input logic [1:0] op);
      return (op == 2'd0) ? 0 : ((op == 2'd3) ? 2 : 1);
   endfunction

   // Issues one command from a negedge; scribbles on the cmd inputs while busy. Returns at the done negedge.
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic [7:0] imm, output int lat, output int we_n, output int rdy_n);
      int guard;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_dst   = dst;
      bus.cmd_src   = src;
      bus.cmd_imm   = imm;
      guard = 0;
      while (!bus.cmd_ready && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      @(negedge CLK);
      lat = 1; we_n = 0; rdy_n = 0;
      while (!bus.done && lat < 20) begin
         bus.cmd_op  = 2'($urandom);
         bus.cmd_dst = 3'($urandom);
         bus.cmd_src = 3'($urandom);
         bus.cmd_imm = 8'($urandom);
         if (bus.bank_we)   we_n++;
         if (bus.cmd_ready) rdy_n++;
         @(negedge CLK);
         lat++;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      #12;
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.bank_we !== 1'b0) begin
         $display("FAIL reset_ctrl ready/done/we got %b%b%b want 100", bus.cmd_ready, bus.done, bus.bank_we);
      end else passed++;
      checks++;
      if (bus.rd_data !== 8'h00 || bus.bank_rsel !== 3'd0 || bus.bank_wsel !== 3'd0 || bus.bank_din !== 8'h00) begin
         $display("FAIL reset_outputs rd_data=%h rsel=%0d wsel=%0d din=%h want all 0",
                  bus.rd_data, bus.bank_rsel, bus.bank_wsel, bus.bank_din);
      end else passed++;
      @(negedge CLK);
      RESET = 1'b0;
      model_clear();
      @(negedge CLK);
   endtask

   task automatic test_ldi_rd();
      int lat, we_n, rdy_n, mi;
      run_cmd(OP_LDI, 3'd3, 3'd0, 8'hA5, lat, we_n, rdy_n);
      model_apply(OP_LDI, 3'd3, 3'd0, 8'hA5);
      checks++;
      if (lat !== 2 || we_n !== 1) $display("FAIL ldi_timing lat=%0d we=%0d want 2 1", lat, we_n);
      else passed++;
      run_cmd(OP_RD, 3'd0, 3'd3, 8'h00, lat, we_n, rdy_n);
      model_apply(OP_RD, 3'd0, 3'd3, 8'h00);
      checks++;
      if (lat !== 2 || we_n !== 0) $display("FAIL rd_timing lat=%0d we=%0d want 2 0", lat, we_n);
      else passed++;
      checks++;
      if (bus.rd_data !== 8'hA5) $display("FAIL rd_data got %h want a5", bus.rd_data);
      else passed++;
      mi = first_mismatch();
      checks++;
      if (mi >= 0) $display("FAIL ldi_rd_regs r%0d got %h want %h", mi, regs[3'(mi)], model[3'(mi)]);
      else passed++;
   endtask

   task automatic test_swap();
      int lat, we_n, rdy_n;
      run_cmd(OP_LDI, 3'd1, 3'd0, 8'h11, lat, we_n, rdy_n);
      model_apply(OP_LDI, 3'd1, 3'd0, 8'h11);
      run_cmd(OP_LDI, 3'd6, 3'd0, 8'hEE, lat, we_n, rdy_n);
      model_apply(OP_LDI, 3'd6, 3'd0, 8'hEE);
      run_cmd(OP_SWAP, 3'd6, 3'd1, 8'h00, lat, we_n, rdy_n);
      model_apply(OP_SWAP, 3'd6, 3'd1, 8'h00);
      checks++;
      if (lat !== 4 || we_n !== 2 || rdy_n !== 0)
         $display("FAIL swap_timing lat=%0d we=%0d busy_ready=%0d want 4 2 0", lat, we_n, rdy_n);
      else passed++;
      checks++;
      if (regs[1] !== 8'hEE || regs[6] !== 8'h11)
         $display("FAIL swap_values r1=%h r6=%h want ee 11", regs[1], regs[6]);
      else passed++;
   endtask

   task automatic test_mov();
      int lat, we_n, rdy_n;
      run_cmd(OP_LDI, 3'd6, 3'd0, 8'h3C, lat, we_n, rdy_n);
      model_apply(OP_LDI, 3'd6, 3'd0, 8'h3C);
      run_cmd(OP_MOV, 3'd0, 3'd6, 8'h00, lat, we_n, rdy_n);
      model_apply(OP_MOV, 3'd0, 3'd6, 8'h00);
      checks++;
      if (lat !== 2 || we_n !== 1) $display("FAIL mov_timing lat=%0d we=%0d want 2 1", lat, we_n);
      else passed++;
      checks++;
      if (regs[0] !== 8'h3C || regs[6] !== 8'h3C)
         $display("FAIL mov_values r0=%h r6=%h want 3c 3c", regs[0], regs[6]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int lat, rdy_n;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_LDI;
      bus.cmd_dst   = 3'd2;
      bus.cmd_src   = 3'd7;
      bus.cmd_imm   = 8'h55;
      @(negedge CLK);
      bus.cmd_op  = OP_RD;
      bus.cmd_dst = 3'd5;
      bus.cmd_src = 3'd2;
      bus.cmd_imm = 8'hFF;
      lat = 1; rdy_n = 0;
      while (!bus.done && lat < 20) begin
         if (bus.cmd_ready) rdy_n++;
         @(negedge CLK);
         lat++;
      end
      model_apply(OP_LDI, 3'd2, 3'd7, 8'h55);
      checks++;
      if (lat !== 2 || rdy_n !== 0 || bus.cmd_ready !== 1'b1)
         $display("FAIL b2b_first lat=%0d busy_ready=%0d ready_in_done=%b want 2 0 1", lat, rdy_n, bus.cmd_ready);
      else passed++;
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL b2b_second_accept ready=%b done=%b want 0 0", bus.cmd_ready, bus.done);
      else passed++;
      @(negedge CLK);
      model_apply(OP_RD, 3'd5, 3'd2, 8'hFF);
      checks++;
      if (bus.done !== 1'b1 || bus.rd_data !== 8'h55)
         $display("FAIL b2b_rd done=%b rd_data=%h want 1 55", bus.done, bus.rd_data);
      else passed++;
   endtask

   task automatic test_swap_same();
      int lat, we_n, rdy_n, mi;
      run_cmd(OP_LDI, 3'd4, 3'd0, 8'h7F, lat, we_n, rdy_n);
      model_apply(OP_LDI, 3'd4, 3'd0, 8'h7F);
      run_cmd(OP_SWAP, 3'd4, 3'd4, 8'h00, lat, we_n, rdy_n);
      model_apply(OP_SWAP, 3'd4, 3'd4, 8'h00);
      checks++;
      if (lat !== 4 || we_n !== 2 || regs[4] !== 8'h7F)
         $display("FAIL swap_same lat=%0d we=%0d r4=%h want 4 2 7f", lat, we_n, regs[4]);
      else passed++;
      mi = first_mismatch();
      checks++;
      if (mi >= 0) $display("FAIL swap_same_regs r%0d got %h want %h", mi, regs[3'(mi)], model[3'(mi)]);
      else passed++;
   endtask

   task automatic test_random();
      int lat, we_n, rdy_n, mi;
      logic [1:0] op;
      logic [2:0] dst, src;
      logic [7:0] imm;
      for (int n = 0; n < 40; n++) begin
         op  = 2'($urandom);
         dst = 3'($urandom);
         src = 3'($urandom);
         imm = 8'($urandom);
         run_cmd(op, dst, src, imm, lat, we_n, rdy_n);
         model_apply(op, dst, src, imm);
         checks++;
         if (lat !== exp_lat(op) || we_n !== exp_we(op) || rdy_n !== 0)
            $display("FAIL rand_timing n=%0d op=%0d lat=%0d we=%0d busy_ready=%0d want %0d %0d 0",
                     n, op, lat, we_n, rdy_n, exp_lat(op), exp_we(op));
         else passed++;
         checks++;
         if (bus.rd_data !== model_rd)
            $display("FAIL rand_rd_data n=%0d op=%0d got %h want %h", n, op, bus.rd_data, model_rd);
         else passed++;
         mi = first_mismatch();
         checks++;
         if (mi >= 0)
            $display("FAIL rand_regs n=%0d op=%0d r%0d got %h want %h", n, op, mi, regs[3'(mi)], model[3'(mi)]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_swap();
      int lat, we_n, rdy_n, mi;
      run_cmd(OP_LDI, 3'd5, 3'd0, 8'h5A, lat, we_n, rdy_n);
      run_cmd(OP_LDI, 3'd2, 3'd0, 8'h99, lat, we_n, rdy_n);
      run_cmd(OP_RD, 3'd0, 3'd2, 8'h00, lat, we_n, rdy_n);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_SWAP;
      bus.cmd_src   = 3'd5;
      bus.cmd_dst   = 3'd2;
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.bank_we !== 1'b1) $display("FAIL mid_swap_we before reset got %b want 1", bus.bank_we);
      else passed++;
      RESET = 1'b1;
      #1;
      model_clear();
      checks++;
      if (bus.bank_we !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.rd_data !== 8'h00)
         $display("FAIL mid_swap_reset we=%b ready=%b done=%b rd_data=%h want 0 1 0 00",
                  bus.bank_we, bus.cmd_ready, bus.done, bus.rd_data);
      else passed++;
      mi = first_mismatch();
      checks++;
      if (mi >= 0) $display("FAIL mid_swap_regs r%0d got %h want 00", mi, regs[3'(mi)]);
      else passed++;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1)
         $display("FAIL abandoned_swap done=%b ready=%b want 0 1", bus.done, bus.cmd_ready);
      else passed++;
      run_cmd(OP_RD, 3'd0, 3'd2, 8'h00, lat, we_n, rdy_n);
      checks++;
      if (lat !== 2 || bus.rd_data !== 8'h00)
         $display("FAIL post_reset_rd lat=%0d rd_data=%h want 2 00", lat, bus.rd_data);
      else passed++;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_dst   = 3'd0;
      bus.cmd_src   = 3'd0;
      bus.cmd_imm   = 8'h00;
      model_clear();
      test_reset();
      test_ldi_rd();
      test_swap();
      test_mov();
      test_back_to_back();
      test_swap_same();
      test_random();
      test_reset_mid_swap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, passed=%0d checks=%0d", passed, checks);
      $fatal(1);
   end
endmodule
